// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH pipeline stage registers with per-stage stall/flush,
// output backpressure, occupancy and saturating squash accounting.
module pipe_stage_chain #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 4,
    parameter bit          FLUSH_ZERO = 1'b1
) (
    input  logic                     Clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic [DEPTH-1:0]         stall,
    input  logic [DEPTH-1:0]         flush,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [DEPTH-1:0]         stage_valid,
    output logic [DEPTH*WIDTH-1:0]   stage_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]              squash_cnt
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [15:0]      r_squash;

    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_xfer;
    logic [WIDTH-1:0] w_src [DEPTH];
    logic [16:0]      w_squash_sum;
    logic [OCC_W-1:0] w_occ;

    // Ready ripples from the consumer backwards; a running accumulator keeps
    // each bit free of reads from its own vector.
    always_comb begin : ready_chain
        logic w_acc;
        w_acc   = out_ready;
        w_ready = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_acc = !stall[DEPTH-1-k] && (!r_valid[DEPTH-1-k] || w_acc);
            w_ready[DEPTH-1-k] = w_acc;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_xfer[g] = in_valid;
            assign w_src[g]  = in_data;
        end else begin : g_link
            assign w_xfer[g] = r_valid[g-1] && !stall[g-1];
            assign w_src[g]  = r_data[g-1];
        end
        assign stage_data[g*WIDTH +: WIDTH] = r_data[g];
    end

    // A flushed stage destroys whatever it would have held after the edge:
    // the incoming entry when it is loading, otherwise its current entry.
    always_comb begin
        w_squash_sum = {1'b0, r_squash};
        w_occ        = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (flush[k] && (w_ready[k] ? w_xfer[k] : r_valid[k])) begin
                w_squash_sum = w_squash_sum + 17'd1;
            end
            w_occ = w_occ + OCC_W'(r_valid[k]);
        end
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_valid  <= '0;
            r_squash <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (flush[k]) begin
                    r_valid[k] <= 1'b0;
                    if (FLUSH_ZERO) begin
                        r_data[k] <= '0;
                    end
                end else if (w_ready[k]) begin
                    r_valid[k] <= w_xfer[k];
                    r_data[k]  <= w_src[k];
                end
            end
            r_squash <= w_squash_sum[16] ? 16'hFFFF : w_squash_sum[15:0];
        end
    end

    assign in_ready    = w_ready[0];
    assign out_valid   = r_valid[DEPTH-1] && !stall[DEPTH-1];
    assign out_data    = r_data[DEPTH-1];
    assign stage_valid = r_valid;
    assign occupancy   = w_occ;
    assign squash_cnt  = r_squash;

endmodule
